// File: rtl/vp_ps2_key_rx.sv
// PS/2 keyboard receiver for the Videopac console front-end.
// Synchronises and debounces the PS/2 lines, deserialises 11-bit frames
// (start, 8 data LSB first, odd parity, stop) and folds the E0/F0 prefixes
// into an 11-bit key event word {toggle, pressed, ext, code[7:0]}.
// A consumer detects a new event by a change in bit 10.
module vp_ps2_key_rx #(
  parameter int FILTER_LEN  = 8,      // 2..15 equal synced samples before the filtered clock moves
  parameter int TIMEOUT_CYC = 20000   // mid-frame stall limit, fits the 16-bit counter
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic        ps2_clk_i,
  input  logic        ps2_dat_i,
  output logic [10:0] ps2_key_o,
  output logic        frame_err_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [3:0]  FLT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_REL   = 8'hF0;
  localparam logic [7:0] CODE_PAUSE = 8'hE1;

  logic [1:0]  clk_sync;
  logic [1:0]  dat_sync;
  logic        clk_filt;
  logic        clk_filt_d;
  logic [3:0]  flt_cnt;
  logic        fall;
  logic        dat;

  state_t      state;
  state_t      state_d;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_q;
  logic        par_q;
  logic [15:0] to_cnt;
  logic        to_tick;
  logic        stop_done;
  logic        timeout;
  logic        frame_ok;

  logic        commit_q;
  logic [7:0]  byte_q;
  logic        ext_q;
  logic        rel_q;

  assign dat      = dat_sync[1];
  assign fall     = clk_filt_d & ~clk_filt;
  assign busy_o   = (state != IDLE);
  // Stop bit must be 1 and data plus parity must carry an odd number of ones.
  assign frame_ok = dat & (^{shift_q, par_q});

  // Two-flop synchronisers on both lines, then a run-length filter on the clock.
  // NOTE: preset to 1 (the idle line level) so leaving reset never fakes a falling edge.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      flt_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // which is what makes the two-stage shift a real synchroniser.
      clk_sync   <= {clk_sync[0], ps2_clk_i};
      dat_sync   <= {dat_sync[0], ps2_dat_i};
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        clk_filt <= clk_sync[1];
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + 4'd1;
      end
    end
  end

  // Frame FSM next-state logic; a sampling edge takes priority over a timeout.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state;
    stop_done = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE:   if (fall && !dat)           state_d = DATA;
      DATA:   if (fall && bit_cnt == 3'd7) state_d = PARITY;
      PARITY: if (fall)                   state_d = STOP;
      STOP:   if (fall) begin
                state_d   = IDLE;
                stop_done = 1'b1;
              end
      default: state_d = IDLE;
    endcase
    if (state != IDLE && !fall && to_cnt == TO_LAST) begin
      state_d = IDLE;
      timeout = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) state <= IDLE;
    else          state <= state_d;
  end

  // Shift register, bit counter, parity capture and the half-rate stall counter.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      bit_cnt <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      to_cnt  <= '0;
      to_tick <= 1'b0;
    end else begin
      if (fall) begin
        case (state)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shift_q <= {dat, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_q <= dat;
          default: ;
        endcase
      end
      if (state == IDLE || fall) begin
        to_cnt  <= '0;
        to_tick <= 1'b0;
      end else begin
        to_tick <= ~to_tick;
        if (to_tick) to_cnt <= to_cnt + 16'd1;
      end
    end
  end

  // Error pulse, prefix flags and key word; a good byte is committed one cycle
  // after the stop-bit edge so the word appears two cycles after it.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      commit_q    <= 1'b0;
      byte_q      <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      frame_err_o <= 1'b0;
      ps2_key_o   <= '0;
    end else begin
      commit_q    <= stop_done & frame_ok;
      frame_err_o <= (stop_done & ~frame_ok) | timeout;
      if (stop_done) byte_q <= shift_q;
      if ((stop_done && !frame_ok) || timeout) begin
        ext_q <= 1'b0;
        rel_q <= 1'b0;
      end else if (commit_q) begin
        case (byte_q)
          CODE_EXT:   ext_q <= 1'b1;
          CODE_REL:   rel_q <= 1'b1;
          CODE_PAUSE: ;
          default: begin
            ps2_key_o <= {~ps2_key_o[10], ~rel_q, ext_q, byte_q};
            ext_q     <= 1'b0;
            rel_q     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vp_ps2_key_rx.sv
// Scoreboard bench for vp_ps2_key_rx: stimulus pushes expected events,
// a monitor pops them whenever the key word changes or an error pulses.
module tb_vp_ps2_key_rx;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 200;

  typedef struct {
    logic        is_err;
    logic [10:0] key;
  } event_t;

  logic        clk_i = 1'b0;
  logic        res_n_i = 1'b0;
  logic        ps2_clk_i = 1'b1;
  logic        ps2_dat_i = 1'b1;
  logic [10:0] ps2_key_o;
  logic        frame_err_o;
  logic        busy_o;

  event_t      exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  vp_ps2_key_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_i       (clk_i),
    .res_n_i     (res_n_i),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_dat_i   (ps2_dat_i),
    .ps2_key_o   (ps2_key_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic expect_key(input logic [10:0] k);
    event_t e;
    e.is_err = 1'b0;
    e.key    = k;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    event_t e;
    e.is_err = 1'b1;
    e.key    = '0;
    exp_q.push_back(e);
  endtask

  // One PS/2 bit: data set while the clock is high, then an 80-cycle clock period.
  task automatic ps2_bit(input logic b);
    ps2_dat_i = b;
    cyc(20);
    ps2_clk_i = 1'b0;
    cyc(40);
    ps2_clk_i = 1'b1;
    cyc(20);
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par, input logic chk_busy);
    logic par;
    par = ~^b ^ bad_par;
    ps2_bit(1'b0);
    if (chk_busy) check("busy_mid_frame", busy_o, 1'b1);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    ps2_dat_i = 1'b1;
    cyc(20);
    if (chk_busy) check("busy_after_frame", busy_o, 1'b0);
  endtask

  // Monitor: every key change or error pulse must match the head of the queue.
  logic [10:0] last_key = '0;
  logic        err_prev = 1'b0;
  always @(negedge clk_i) begin
    event_t e;
    if (!res_n_i) begin
      last_key = '0;
      err_prev = 1'b0;
    end else begin
      if (err_prev) begin
        check("err_pulse_width", frame_err_o, 1'b0);
      end else if (frame_err_o) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_err: got error pulse, required none");
        end else begin
          e = exp_q.pop_front();
          check("event_is_err", 1'b1, e.is_err);
        end
      end
      err_prev = frame_err_o;
      if (ps2_key_o !== last_key) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_key: got %0h, required no change from %0h", ps2_key_o, last_key);
        end else begin
          e = exp_q.pop_front();
          check("event_is_key", 1'b0, e.is_err);
          check("key_word", ps2_key_o, e.key);
        end
      end
      last_key = ps2_key_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    check("reset_key", ps2_key_o, 11'h000);
    check("reset_err", frame_err_o, 1'b0);
    check("reset_busy", busy_o, 1'b0);
    res_n_i = 1'b1;
    cyc(20);

    // 1: plain make code, toggle 0->1, pressed, not extended.
    expect_key(11'h61C);
    send(8'h1C, 1'b0, 1'b1);

    // 2: release prefix, toggle back to 0, pressed=0.
    send(8'hF0, 1'b0, 1'b0);
    expect_key(11'h01C);
    send(8'h1C, 1'b0, 1'b0);

    // 3: extended make {1,1,1,75}, then extended break {0,0,1,75}.
    send(8'hE0, 1'b0, 1'b0);
    expect_key(11'h775);
    send(8'h75, 1'b0, 1'b0);
    send(8'hE0, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0);
    expect_key(11'h175);
    send(8'h75, 1'b0, 1'b0);

    // 4: E1 is discarded, parity error drops the pending E0, next 1C is plain.
    send(8'hE0, 1'b0, 1'b0);
    send(8'hE1, 1'b0, 1'b0);
    expect_err();
    send(8'h1C, 1'b1, 1'b0);
    expect_key(11'h61C);
    send(8'h1C, 1'b0, 1'b0);

    // 5: short clock glitch in IDLE is ignored.
    ps2_clk_i = 1'b0;
    cyc(FILTER_LEN - 1);
    ps2_clk_i = 1'b1;
    cyc(30);
    check("glitch_busy", busy_o, 1'b0);

    // 5: stall after 4 data bits of 0x16 -> timeout error, then a good 0x16.
    expect_err();
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_dat_i = 1'b1;
    check("stall_busy", busy_o, 1'b1);
    for (int i = 0; i < 4 * TIMEOUT_CYC && busy_o; i++) cyc(1);
    check("timeout_idle", busy_o, 1'b0);
    cyc(10);
    expect_key(11'h216);
    send(8'h16, 1'b0, 1'b0);

    // 6: reset mid-DATA clears everything asynchronously.
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    check("pre_reset_busy", busy_o, 1'b1);
    @(posedge clk_i);
    #2 res_n_i = 1'b0;
    #1;
    check("async_reset_key", ps2_key_o, 11'h000);
    check("async_reset_busy", busy_o, 1'b0);
    check("async_reset_err", frame_err_o, 1'b0);
    @(posedge clk_i);
    #2 res_n_i = 1'b1;
    cyc(20);
    expect_key(11'h645);
    send(8'h45, 1'b0, 1'b0);

    cyc(50);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
